trace_packer: RTL and testbench
===============================

# trace_packer

Single-clock, parametrised trace capture and packing unit, the successor to the fixed-width tracer front end of the trace logger. It samples a selectable-width slice of a trace bus, with optional decimation, and packs consecutive samples LSB-first into memory-width words. It tags the word containing the first trigger and stops a programmable number of words after it (trace mode), or runs continuously (stream mode). Completed words leave through a one-deep valid/permit output register toward the logger/memory side. Overrun is flagged sticky.

## Interface
- `WORD_WIDTH`, default 64: packed word width; power of two, at least `MAX_TRACES`.
- `MAX_TRACES`, default 32: trace bus width; power of two.
- `DELAY_WIDTH`, default 16: width of the post-trigger word counter.
- `DECIM_WIDTH`, default 8: width of the decimation divider.

Ports:
- `CLK_I` in 1: single clock.
- `RST_I` in 1: synchronous, active-high reset.
- `ARM_I` in 1: pulse; latches configuration and starts capture; honoured only in IDLE or DONE.
- `MODE_I` in 1: 0 = trace mode, 1 = stream mode.
- `NTRACE_I` in $clog2(MAX_TRACES)+1: k; sample width = 2^k; values with 2^k > MAX_TRACES are clamped to MAX_TRACES.
- `DELAY_I` in DELAY_WIDTH: number of words stored after the trigger word (trace mode).
- `DECIM_I` in DECIM_WIDTH: one sample accepted every DECIM_I+1 enabled cycles.
- `SAMPLE_EN_I` in 1: qualifies cycles for sampling.
- `TRIG_I` in 1: trigger input.
- `TRACE_I` in MAX_TRACES: trace bus; bits [w-1:0] are sampled.
- `DATA_O` out WORD_WIDTH: packed word.
- `STORE_O` out 1: DATA_O valid; held until accepted.
- `STORE_PERM_I` in 1: consumer accepts DATA_O while STORE_O=1.
- `TRG_EVENT_O` out 1: DATA_O holds the trigger sample; qualified by STORE_O.
- `EVENT_POS_O` out $clog2(WORD_WIDTH): bit index of the trigger sample in DATA_O.
- `TRIG_O` out 1: high from acceptance of the trigger word until re-arm or reset.
- `BUSY_O` out 1: state is ARMED or POST.
- `OVERFLOW_O` out 1: sticky; a completed word was dropped.

## Operation
- States:
  - IDLE (after reset).
  - ARMED: capturing, no trigger seen yet.
  - POST: trigger seen.
  - DONE: trace mode only.
- State transitions:
  - IDLE/DONE + ARM_I → ARMED. Latches MODE, NTRACE, DELAY and DECIM. Clears the packing index, decimation counter, pending trigger, TRIG_O and OVERFLOW_O.
  - ARMED → POST when a trigger-tagged sample is accepted.
  - POST → DONE in trace mode, when the word completing the DELAY-th post-trigger word is stored.
  - In stream mode, POST persists until reset. Later triggers are ignored.
- Sample acceptance:
  - Applies in ARMED/POST on cycles with SAMPLE_EN_I=1.
  - The decimation counter increments on each such cycle; a sample is accepted when it equals DECIM and it then wraps to 0.
  - DECIM=0 accepts every enabled cycle.
- Packing:
  - Sample width w = 2^k; a word holds S = WORD_WIDTH/w samples.
  - Sample i (0..S-1) is written to bits [i·w +: w]. The index wraps at S-1, which completes the word.
- Trigger:
  - TRIG_I=1 in ARMED sets a pending flag, including on non-accepted cycles.
  - The next accepted sample consumes the flag and becomes the trigger sample; its position is i·w.
  - Only the first trigger per arm is used.
- Output register:
  - A completed word loads into the register if it is empty, or if it is being accepted in the same cycle (STORE_O & STORE_PERM_I).
  - Otherwise the word is dropped and OVERFLOW_O is set.
  - A dropped trigger word still moves the FSM to POST, but TRG_EVENT_O is lost; TRIG_O then rises on the drop cycle.
- Post-trigger counting: the counter counts completed words after the trigger word, dropped words included. DELAY=0 means the trigger word is the last word.
- Leaving capture: a partial word is discarded on DONE or on reset. The output register keeps its word until accepted, including in DONE.
- Configuration inputs are ignored outside ARM_I.

## Timing
- Reset values: all outputs 0, state IDLE. Reset mid-capture discards the held word.
- Latency: the sample accepted at cycle t that completes a word gives STORE_O=1 at t+1, with DATA_O, TRG_EVENT_O and EVENT_POS_O valid at t+1.
- Handshake: a transfer happens on a cycle with STORE_O & STORE_PERM_I. STORE_O falls the next cycle unless a new word loads.
- Throughput: with w = WORD_WIDTH and a permanent permit, one word per cycle.
- TRIG_O rises the cycle after the transfer of the trigger word.
- DONE is entered the cycle after the final word completes. BUSY_O falls in that same cycle.
- ARM_I and RST_I in the same cycle: reset wins.

## Structure
- Shared package (`DTB_PKG`): state enum `packer_state_t`, a `packer_cfg_t` struct (mode, ntrace, delay, decim), and the default width constants.
- Natural sub-module: `trace_out_reg`, a one-deep valid/permit register with a drop/overflow output, reusable for other stream paths.

## Test plan
- WORD_WIDTH=64, k=3, DECIM=0, trace mode, DELAY=2, permit always 1, TRACE=sample count 0x00..; trigger at sample 10 → words: 0x0706050403020100, then the trigger word with EVENT_POS=16 and TRG_EVENT=1, then 2 more words, then DONE; TRIG_O is high after the trigger word.
- k=0, DECIM=3, TRACE[0] toggling each cycle → 1 sample per 4 enabled cycles; the first word completes after 256 cycles (all bits equal to the phase-aligned value).
- TRIG_I pulse on a non-accepted cycle (DECIM=7) → it tags the next accepted sample; a second trigger later is ignored.
- Permit held low for 2 word periods, k=6 → first word held on DATA_O, second word dropped, OVERFLOW_O=1 sticky until ARM_I.
- Stream mode, DELAY=0 → no DONE after the trigger word; capture continues; BUSY_O stays 1.
- RST_I asserted mid-word with STORE_O=1 → all outputs 0 next cycle, state IDLE; ARM_I then restarts at packing index 0.

Source files
------------

// File: rtl/trace_packer_pkg.sv
// Shared types and default widths for the trace packer and its output register.
package DTB_PKG;

  localparam int DEF_WORD_WIDTH  = 64;
  localparam int DEF_MAX_TRACES  = 32;
  localparam int DEF_DELAY_WIDTH = 16;
  localparam int DEF_DECIM_WIDTH = 8;

  // Configuration fields are sized for the largest supported parameter values.
  localparam int CFG_NTRACE_W = 8;
  localparam int CFG_COUNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } packer_state_t;

  typedef struct packed {
    logic                    mode;
    logic [CFG_NTRACE_W-1:0] ntrace;
    logic [CFG_COUNT_W-1:0]  delay;
    logic [CFG_COUNT_W-1:0]  decim;
  } packer_cfg_t;

  function automatic logic [CFG_NTRACE_W-1:0] clamp_ntrace(input logic [CFG_NTRACE_W-1:0] k,
                                                           input int kmax);
    if (int'(k) > kmax) return CFG_NTRACE_W'(kmax);
    return k;
  endfunction

endpackage

// File: rtl/trace_out_reg.sv
// One-deep valid/permit output register; a word offered while it is full and not
// being drained is dropped and reported on drop.
module trace_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         perm,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         drop
);

  assign drop = load & valid & ~perm;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && (!valid || perm)) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && perm) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/trace_packer.sv
// Trace capture and packing unit: decimated samples of 2^k bits are packed LSB-first
// into words, the trigger word is tagged, and capture stops DELAY words later.
module trace_packer
  import DTB_PKG::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int MAX_TRACES  = DEF_MAX_TRACES,
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int DECIM_WIDTH = DEF_DECIM_WIDTH
) (
  input  logic                            CLK_I,
  input  logic                            RST_I,
  input  logic                            ARM_I,
  input  logic                            MODE_I,
  input  logic [$clog2(MAX_TRACES):0]     NTRACE_I,
  input  logic [DELAY_WIDTH-1:0]          DELAY_I,
  input  logic [DECIM_WIDTH-1:0]          DECIM_I,
  input  logic                            SAMPLE_EN_I,
  input  logic                            TRIG_I,
  input  logic [MAX_TRACES-1:0]           TRACE_I,
  output logic [WORD_WIDTH-1:0]           DATA_O,
  output logic                            STORE_O,
  input  logic                            STORE_PERM_I,
  output logic                            TRG_EVENT_O,
  output logic [$clog2(WORD_WIDTH)-1:0]   EVENT_POS_O,
  output logic                            TRIG_O,
  output logic                            BUSY_O,
  output logic                            OVERFLOW_O
);

  localparam int KMAX = $clog2(MAX_TRACES);
  localparam int IW   = $clog2(WORD_WIDTH);
  localparam int PW   = WORD_WIDTH + IW + 1;

  packer_state_t state, state_nxt;
  packer_cfg_t   cfg;

  logic [IW-1:0]          idx, trig_pos, bit_pos, last_idx, pos_nxt;
  logic [DECIM_WIDTH-1:0] dec_cnt;
  logic [DELAY_WIDTH-1:0] post_cnt;
  logic [WORD_WIDTH-1:0]  word_buf, word_nxt, sample_mask;
  logic [IW:0]            sample_w;
  logic                   trig_pend, trig_in_word, trig_q, ovf_q;
  logic                   arm, capturing, accept, last, word_done, trig_hit, word_trig, final_word;
  logic                   out_valid, out_trg, drop;
  logic [PW-1:0]          out_payload;

  assign capturing = (state == ST_ARMED) || (state == ST_POST);
  assign arm       = ARM_I && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept    = capturing && SAMPLE_EN_I && (CFG_COUNT_W'(dec_cnt) == cfg.decim);

  assign last_idx  = IW'((WORD_WIDTH >> cfg.ntrace) - 1);
  assign last      = (idx == last_idx);
  assign word_done = accept && last;
  assign trig_hit  = accept && (state == ST_ARMED) && (trig_pend || TRIG_I);
  assign word_trig = trig_in_word || trig_hit;

  // Merge the new sample into its slot; the mask wraps to all ones when w == WORD_WIDTH.
  assign bit_pos     = idx << cfg.ntrace;
  assign sample_w    = {{IW{1'b0}}, 1'b1} << cfg.ntrace;
  assign sample_mask = ~({WORD_WIDTH{1'b1}} << sample_w);
  assign word_nxt    = (word_buf & ~(sample_mask << bit_pos)) |
                       ((WORD_WIDTH'(TRACE_I) & sample_mask) << bit_pos);
  assign pos_nxt     = trig_hit ? bit_pos : trig_pos;

  assign final_word = !cfg.mode && word_done &&
                      (word_trig ? (cfg.delay == '0)
                                 : ((state == ST_POST) &&
                                    ((CFG_COUNT_W'(post_cnt) + CFG_COUNT_W'(1)) == cfg.delay)));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (ARM_I) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (final_word)    state_nxt = ST_DONE;
        else if (trig_hit) state_nxt = ST_POST;
      end
      ST_POST: if (final_word) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cfg          <= '0;
      idx          <= '0;
      dec_cnt      <= '0;
      post_cnt     <= '0;
      word_buf     <= '0;
      trig_pend    <= 1'b0;
      trig_in_word <= 1'b0;
      trig_pos     <= '0;
      trig_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (arm) begin
      cfg.mode     <= MODE_I;
      cfg.ntrace   <= clamp_ntrace(CFG_NTRACE_W'(NTRACE_I), KMAX);
      cfg.delay    <= CFG_COUNT_W'(DELAY_I);
      cfg.decim    <= CFG_COUNT_W'(DECIM_I);
      idx          <= '0;
      dec_cnt      <= '0;
      post_cnt     <= '0;
      trig_pend    <= 1'b0;
      trig_in_word <= 1'b0;
      trig_pos     <= '0;
      trig_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (capturing && SAMPLE_EN_I) dec_cnt <= accept ? '0 : dec_cnt + 1'b1;
      if (accept) begin
        word_buf <= word_nxt;
        idx      <= last ? '0 : idx + 1'b1;
      end
      trig_pend <= (state == ST_ARMED) && (trig_pend || TRIG_I) && !accept;
      if (word_done) begin
        trig_in_word <= 1'b0;
      end else if (trig_hit) begin
        trig_in_word <= 1'b1;
        trig_pos     <= bit_pos;
      end
      // Dropped words still advance the post-trigger count.
      if (word_done && word_trig)               post_cnt <= '0;
      else if (word_done && state == ST_POST)   post_cnt <= post_cnt + 1'b1;
      if ((out_valid && STORE_PERM_I && out_trg) || (drop && word_trig)) trig_q <= 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  trace_out_reg #(.W(PW)) u_out_reg (
    .clk      (CLK_I),
    .rst      (RST_I),
    .load     (word_done),
    .load_data({word_trig, pos_nxt, word_nxt}),
    .perm     (STORE_PERM_I),
    .valid    (out_valid),
    .data     (out_payload),
    .drop     (drop)
  );

  assign out_trg     = out_payload[PW-1];
  assign DATA_O      = out_payload[WORD_WIDTH-1:0];
  assign EVENT_POS_O = out_payload[WORD_WIDTH +: IW];
  assign STORE_O     = out_valid;
  assign TRG_EVENT_O = out_valid && out_trg;
  assign TRIG_O      = trig_q;
  assign BUSY_O      = capturing;
  assign OVERFLOW_O  = ovf_q;

endmodule

// File: tb/tb_trace_packer.sv
// Directed bench for trace_packer: a table of single-word captures across sample
// widths, then hand-written sequences for triggering, overrun, stream mode and reset.
module tb_trace_packer;

  localparam int WW  = 64;
  localparam int MT  = 64;
  localparam int DW  = 16;
  localparam int DCW = 8;
  localparam int KW  = $clog2(MT) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          mode = 1'b0;
  logic [KW-1:0] ntrace = '0;
  logic [DW-1:0] delay = '0;
  logic [DCW-1:0] decim = '0;
  logic          sample_en = 1'b0;
  logic          trig = 1'b0;
  logic [MT-1:0] trace = '0;
  logic [WW-1:0] data;
  logic          store;
  logic          perm = 1'b1;
  logic          trg_event;
  logic [5:0]    event_pos;
  logic          trig_o, busy, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          k;
    int          trig_at;
    logic [63:0] pattern;
    logic [63:0] exp_data;
    int          exp_pos;
  } vec_t;

  vec_t        vecs[9];
  logic [63:0] t1_words[4];
  logic [63:0] t3_words[2];

  trace_packer #(.WORD_WIDTH(WW), .MAX_TRACES(MT), .DELAY_WIDTH(DW), .DECIM_WIDTH(DCW)) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .ARM_I       (arm),
    .MODE_I      (mode),
    .NTRACE_I    (ntrace),
    .DELAY_I     (delay),
    .DECIM_I     (decim),
    .SAMPLE_EN_I (sample_en),
    .TRIG_I      (trig),
    .TRACE_I     (trace),
    .DATA_O      (data),
    .STORE_O     (store),
    .STORE_PERM_I(perm),
    .TRG_EVENT_O (trg_event),
    .EVENT_POS_O (event_pos),
    .TRIG_O      (trig_o),
    .BUSY_O      (busy),
    .OVERFLOW_O  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic s_en, input logic s_trig, input logic [63:0] s_trace);
    sample_en = s_en;
    trig      = s_trig;
    trace     = s_trace;
    tick();
  endtask

  task automatic arm_cfg(input logic m, input int k, input int dly, input int dec);
    arm       = 1'b1;
    mode      = m;
    ntrace    = KW'(k);
    delay     = DW'(dly);
    decim     = DCW'(dec);
    sample_en = 1'b0;
    trig      = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_en = 1'b0;
    trig = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nw;
    int first_c;
    int got_c;
    bit got;

    vecs[0] = '{3,  0, 64'h00000000_000000A5, 64'hA5A5A5A5_A5A5A5A5,  0};
    vecs[1] = '{3,  5, 64'h00000000_0000003C, 64'h3C3C3C3C_3C3C3C3C, 40};
    vecs[2] = '{4,  3, 64'h00000000_FFFF1234, 64'h12341234_12341234, 48};
    vecs[3] = '{5,  1, 64'h55555555_DEADBEEF, 64'hDEADBEEF_DEADBEEF, 32};
    vecs[4] = '{6,  0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF,  0};
    vecs[5] = '{7,  0, 64'hFEDCBA98_76543210, 64'hFEDCBA98_76543210,  0};
    vecs[6] = '{0, 63, 64'h00000000_00000001, 64'hFFFFFFFF_FFFFFFFF, 63};
    vecs[7] = '{1, 17, 64'h00000000_00000006, 64'hAAAAAAAA_AAAAAAAA, 34};
    vecs[8] = '{2, 15, 64'h00000000_000000F9, 64'h99999999_99999999, 60};

    t1_words[0] = 64'h07060504_03020100;
    t1_words[1] = 64'h0F0E0D0C_0B0A0908;
    t1_words[2] = 64'h17161514_13121110;
    t1_words[3] = 64'h1F1E1D1C_1B1A1918;

    t3_words[0] = 64'h3F372F27_1F170F07;
    t3_words[1] = 64'h7F776F67_5F574F47;

    // Reset state
    tick();
    tick();
    check_output("rst_store",    64'(store),     64'd0);
    check_output("rst_data",     data,           64'd0);
    check_output("rst_trg",      64'(trg_event), 64'd0);
    check_output("rst_pos",      64'(event_pos), 64'd0);
    check_output("rst_trig_o",   64'(trig_o),    64'd0);
    check_output("rst_busy",     64'(busy),      64'd0);
    check_output("rst_overflow", 64'(overflow),  64'd0);
    rst = 1'b0;

    // Single trigger word per vector, DELAY=0 so each capture ends in DONE
    perm = 1'b1;
    for (int v = 0; v < 9; v++) begin
      int kc;
      int s;
      kc = (vecs[v].k > 6) ? 6 : vecs[v].k;
      s  = WW >> kc;
      got = 1'b0;
      got_c = -1;
      arm_cfg(1'b0, vecs[v].k, 0, 0);
      for (int c = 0; c < s + 4 && !got; c++) begin
        apply_stimulus(1'b1, c == vecs[v].trig_at, vecs[v].pattern);
        if (store) begin
          got = 1'b1;
          got_c = c;
          check_output($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
          check_output($sformatf("vec%0d_trg", v),  64'(trg_event), 64'd1);
          check_output($sformatf("vec%0d_pos", v),  64'(event_pos), 64'(vecs[v].exp_pos));
          check_output($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
        end
      end
      check_output($sformatf("vec%0d_latency", v), 64'(got_c), 64'(s - 1));
      apply_stimulus(1'b0, 1'b0, 64'd0);
    end

    // Trace mode k=3, trigger on sample 10, DELAY=2
    arm_cfg(1'b0, 3, 2, 0);
    nw = 0;
    for (int c = 0; c < 50; c++) begin
      apply_stimulus(1'b1, c == 10, 64'(c));
      if (c == 15) check_output("t1_trig_o_before", 64'(trig_o), 64'd0);
      if (c == 16) check_output("t1_trig_o_rise",   64'(trig_o), 64'd1);
      if (store) begin
        if (nw < 4) begin
          check_output($sformatf("t1_word%0d", nw), data, t1_words[nw]);
          check_output($sformatf("t1_trg%0d", nw), 64'(trg_event), 64'(nw == 1));
          if (nw == 1) check_output("t1_pos", 64'(event_pos), 64'd16);
        end
        nw++;
      end
    end
    check_output("t1_word_count", 64'(nw), 64'd4);
    check_output("t1_busy_done", 64'(busy), 64'd0);
    check_output("t1_trig_o",    64'(trig_o), 64'd1);

    // Trigger on a non-accepted cycle with DECIM=7, later trigger ignored
    arm_cfg(1'b0, 3, 1, 7);
    nw = 0;
    for (int c = 0; c < 200; c++) begin
      apply_stimulus(1'b1, (c == 20) || (c == 79), 64'(c & 8'hFF));
      if (store) begin
        if (nw < 2) begin
          check_output($sformatf("t3_word%0d", nw), data, t3_words[nw]);
          check_output($sformatf("t3_trg%0d", nw), 64'(trg_event), 64'(nw == 0));
          if (nw == 0) check_output("t3_pos", 64'(event_pos), 64'd16);
        end
        nw++;
      end
    end
    check_output("t3_word_count", 64'(nw), 64'd2);
    check_output("t3_busy_done", 64'(busy), 64'd0);

    // Overrun with permit low, k=6
    arm_cfg(1'b0, 6, 0, 0);
    perm = 1'b0;
    apply_stimulus(1'b1, 1'b0, 64'hAAAA_0000_0000_0001);
    check_output("ov_store1", 64'(store), 64'd1);
    check_output("ov_data1",  data, 64'hAAAA_0000_0000_0001);
    check_output("ov_flag0",  64'(overflow), 64'd0);
    apply_stimulus(1'b1, 1'b0, 64'hBBBB_0000_0000_0002);
    check_output("ov_data_held", data, 64'hAAAA_0000_0000_0001);
    check_output("ov_flag1",     64'(overflow), 64'd1);
    apply_stimulus(1'b0, 1'b0, 64'd0);
    check_output("ov_store_held", 64'(store), 64'd1);
    perm = 1'b1;
    apply_stimulus(1'b0, 1'b0, 64'd0);
    check_output("ov_store_drained", 64'(store), 64'd0);
    check_output("ov_sticky",        64'(overflow), 64'd1);
    arm_cfg(1'b0, 6, 0, 0);
    check_output("ov_arm_ignored", 64'(overflow), 64'd1);
    check_output("ov_busy_armed",  64'(busy), 64'd1);
    apply_stimulus(1'b1, 1'b1, 64'hCCCC_0000_0000_0003);
    check_output("ov_trg_word", data, 64'hCCCC_0000_0000_0003);
    check_output("ov_trg_flag", 64'(trg_event), 64'd1);
    check_output("ov_done",     64'(busy), 64'd0);
    arm_cfg(1'b0, 6, 0, 0);
    check_output("ov_cleared",  64'(overflow), 64'd0);

    // k=0, DECIM=3, toggling bit 0: first word after 256 enabled cycles
    do_reset();
    arm_cfg(1'b1, 0, 0, 3);
    first_c = -1;
    for (int c = 0; c < 300 && first_c < 0; c++) begin
      apply_stimulus(1'b1, 1'b0, 64'(c & 1));
      if (store) begin
        first_c = c;
        check_output("dec_data", data, 64'hFFFFFFFF_FFFFFFFF);
      end
    end
    check_output("dec_first_cycle", 64'(first_c), 64'd255);

    // Stream mode, DELAY=0, full-width samples, one word per cycle
    do_reset();
    arm_cfg(1'b1, 6, 0, 0);
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(1'b1, c == 2, 64'h1000 + 64'(c));
      check_output($sformatf("st_data%0d", c), data, 64'h1000 + 64'(c));
      check_output($sformatf("st_store%0d", c), 64'(store), 64'd1);
      if (c == 2) check_output("st_trg", 64'(trg_event), 64'd1);
      if (c == 5) check_output("st_no_retrg", 64'(trg_event), 64'd0);
    end
    check_output("st_busy",   64'(busy), 64'd1);
    check_output("st_trig_o", 64'(trig_o), 64'd1);

    // Reset mid-word while a word is held, ARM during reset must lose
    do_reset();
    arm_cfg(1'b1, 3, 0, 0);
    perm = 1'b0;
    for (int c = 0; c < 11; c++) apply_stimulus(1'b1, c == 0, 64'(c));
    check_output("rs_store_pre", 64'(store), 64'd1);
    rst = 1'b1;
    arm = 1'b1;
    apply_stimulus(1'b0, 1'b0, 64'd0);
    check_output("rs_store", 64'(store),     64'd0);
    check_output("rs_data",  data,           64'd0);
    check_output("rs_trg",   64'(trg_event), 64'd0);
    check_output("rs_pos",   64'(event_pos), 64'd0);
    check_output("rs_busy",  64'(busy),      64'd0);
    apply_stimulus(1'b0, 1'b0, 64'd0);
    check_output("rs_arm_loses", 64'(busy), 64'd0);
    rst = 1'b0;
    arm = 1'b0;
    perm = 1'b1;
    arm_cfg(1'b0, 3, 0, 0);
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      apply_stimulus(1'b1, c == 0, 64'h40 + 64'(c));
      if (store) begin
        got = 1'b1;
        check_output("rs_restart_data", data, 64'h47464544_43424140);
        check_output("rs_restart_cycle", 64'(c), 64'd7);
      end
    end
    check_output("rs_restart_seen", 64'(got), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
